// File: rtl/rca_wb_collector.sv
// Writeback collector: round-robin ack of unit results into an in-order FIFO
// that drains to the commit port. Define RCA_WB_BYPASS_EN for same-cycle empty-FIFO bypass.
module rca_wb_collector #(
    parameter int NUM_UNITS = 4,
    parameter int XLEN      = 32,
    parameter int ID_WIDTH  = 3,
    parameter int DEPTH     = 4,
    localparam int UW       = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1,
    localparam int PW       = $clog2(DEPTH),
    localparam int CW       = $clog2(DEPTH + 1)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_UNITS-1:0]          unit_done,
    input  logic [NUM_UNITS*ID_WIDTH-1:0] unit_id,
    input  logic [NUM_UNITS*XLEN-1:0]     unit_rd,
    output logic [NUM_UNITS-1:0]          unit_ack,
    output logic                          wb_valid,
    output logic [ID_WIDTH-1:0]           wb_id,
    output logic [XLEN-1:0]               wb_rd,
    output logic [UW-1:0]                 wb_unit,
    input  logic                          wb_ready
);
    logic [ID_WIDTH-1:0] mem_id   [DEPTH];
    logic [XLEN-1:0]     mem_rd   [DEPTH];
    logic [UW-1:0]       mem_unit [DEPTH];

    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic [UW-1:0] rr_ptr, grant;
    logic          any_req, space, ack, push, pop, fifo_valid;
    logic [ID_WIDTH-1:0] g_id;
    logic [XLEN-1:0]     g_rd;

    // Walk downward so the unit closest to rr_ptr is the last (winning) assignment.
    always_comb begin
        grant   = '0;
        any_req = 1'b0;
        for (int i = NUM_UNITS - 1; i >= 0; i--) begin
            if (unit_done[(int'(rr_ptr) + i) % NUM_UNITS]) begin
                grant   = UW'((int'(rr_ptr) + i) % NUM_UNITS);
                any_req = 1'b1;
            end
        end
    end

    // space uses the FIFO head rather than wb_valid so bypass cannot form a loop.
    assign fifo_valid = (count != '0);
    assign pop        = fifo_valid && wb_ready;
    assign space      = (count < CW'(DEPTH)) || pop;
    assign ack        = any_req && space && !rst;
    assign g_id       = unit_id[int'(grant)*ID_WIDTH +: ID_WIDTH];
    assign g_rd       = unit_rd[int'(grant)*XLEN +: XLEN];

    always_comb begin
        unit_ack = '0;
        if (ack) unit_ack[grant] = 1'b1;
    end

`ifdef RCA_WB_BYPASS_EN
    logic bypass;
    assign bypass = ack && !fifo_valid;
    assign push   = ack && !(bypass && wb_ready);

    always_comb begin
        wb_valid = 1'b0;
        wb_id    = '0;
        wb_rd    = '0;
        wb_unit  = '0;
        if (fifo_valid) begin
            wb_valid = 1'b1;
            wb_id    = mem_id[rd_ptr];
            wb_rd    = mem_rd[rd_ptr];
            wb_unit  = mem_unit[rd_ptr];
        end else if (bypass) begin
            wb_valid = 1'b1;
            wb_id    = g_id;
            wb_rd    = g_rd;
            wb_unit  = grant;
        end
    end
`else
    assign push = ack;

    always_comb begin
        wb_valid = fifo_valid;
        wb_id    = '0;
        wb_rd    = '0;
        wb_unit  = '0;
        if (fifo_valid) begin
            wb_id   = mem_id[rd_ptr];
            wb_rd   = mem_rd[rd_ptr];
            wb_unit = mem_unit[rd_ptr];
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (push) begin
            mem_id[wr_ptr]   <= g_id;
            mem_rd[wr_ptr]   <= g_rd;
            mem_unit[wr_ptr] <= grant;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            rr_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
            if (ack)
                rr_ptr <= (int'(grant) == NUM_UNITS - 1) ? '0 : grant + 1'b1;
        end
    end
endmodule

// File: tb/tb_rca_wb_collector.sv
// Directed bench for rca_wb_collector (default build, 4 units, DEPTH 4).
module tb_rca_wb_collector;
    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   unit_done;
    logic [11:0]  unit_id;
    logic [127:0] unit_rd;
    logic [3:0]   unit_ack;
    logic         wb_valid;
    logic [2:0]   wb_id;
    logic [31:0]  wb_rd;
    logic [1:0]   wb_unit;
    logic         wb_ready;

    int total = 0;
    int fails = 0;

    rca_wb_collector #(.NUM_UNITS(4), .XLEN(32), .ID_WIDTH(3), .DEPTH(4)) dut (
        .clk(clk), .rst(rst), .unit_done(unit_done), .unit_id(unit_id),
        .unit_rd(unit_rd), .unit_ack(unit_ack), .wb_valid(wb_valid),
        .wb_id(wb_id), .wb_rd(wb_rd), .wb_unit(wb_unit), .wb_ready(wb_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rdv(input logic [2:0] id);
        return {8'hA0, 21'h0, id};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_u(input int u, input logic d, input logic [2:0] id);
        unit_done[u]         = d;
        unit_id[u*3 +: 3]    = id;
        unit_rd[u*32 +: 32]  = rdv(id);
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b0; unit_done = '0; unit_id = '0; unit_rd = '0; wb_ready = 1'b0;
        #1 rst = 1'b1;
        set_u(0, 1'b1, 3'd3);
        sample();
        chk("rst_ack", {28'h0, unit_ack}, 32'h0);
        chk("rst_valid", {31'h0, wb_valid}, 32'h0);
        chk("rst_id", {29'h0, wb_id}, 32'h0);
        chk("rst_rd", wb_rd, 32'h0);
        chk("rst_unit", {30'h0, wb_unit}, 32'h0);
        set_u(0, 1'b0, 3'd0);
        rst = 1'b0;

        // single result from unit 1
        next(); set_u(1, 1'b1, 3'd5); unit_rd[32 +: 32] = 32'h0000_00FF; wb_ready = 1'b1;
        sample();
        chk("single_ack", {28'h0, unit_ack}, 32'h2);
        chk("single_nolat", {31'h0, wb_valid}, 32'h0);
        next(); set_u(1, 1'b0, 3'd0);
        sample();
        chk("single_valid", {31'h0, wb_valid}, 32'h1);
        chk("single_id", {29'h0, wb_id}, 32'd5);
        chk("single_rd", wb_rd, 32'hFF);
        chk("single_unit", {30'h0, wb_unit}, 32'd1);
        chk("single_ack0", {28'h0, unit_ack}, 32'h0);
        next(); sample();
        chk("single_empty", {31'h0, wb_valid}, 32'h0);

        // back-pressure, rr_ptr now 2
        next(); wb_ready = 1'b0;
        for (int u = 0; u < 4; u++) set_u(u, 1'b1, 3'(u));
        sample(); chk("bp_ack_a", {28'h0, unit_ack}, 32'h4);
        next(); set_u(2, 1'b0, 3'd0);
        sample(); chk("bp_ack_b", {28'h0, unit_ack}, 32'h8);
        chk("bp_head", {29'h0, wb_id}, 32'd2);
        next(); set_u(3, 1'b0, 3'd0);
        sample(); chk("bp_ack_c", {28'h0, unit_ack}, 32'h1);
        next(); set_u(0, 1'b1, 3'd4);
        sample(); chk("bp_ack_d", {28'h0, unit_ack}, 32'h2);
        next(); set_u(1, 1'b1, 3'd5);
        sample(); chk("bp_full_a", {28'h0, unit_ack}, 32'h0);
        chk("bp_full_head", {29'h0, wb_id}, 32'd2);
        next(); sample(); chk("bp_full_b", {28'h0, unit_ack}, 32'h0);
        next(); wb_ready = 1'b1;
        sample(); chk("bp_rel_id", {29'h0, wb_id}, 32'd2);
        chk("bp_rel_unit", {30'h0, wb_unit}, 32'd2);
        chk("bp_rel_ack", {28'h0, unit_ack}, 32'h1);
        next(); set_u(0, 1'b0, 3'd0);
        sample(); chk("bp_id3", {29'h0, wb_id}, 32'd3);
        chk("bp_unit3", {30'h0, wb_unit}, 32'd3);
        chk("bp_ack_f", {28'h0, unit_ack}, 32'h2);
        next(); set_u(1, 1'b0, 3'd0); wb_ready = 1'b0;
        sample(); chk("bp_id0", {29'h0, wb_id}, 32'd0);
        chk("bp_idle_ack", {28'h0, unit_ack}, 32'h0);

        // full FIFO with simultaneous pop, rr_ptr 2
        next(); wb_ready = 1'b1; set_u(2, 1'b1, 3'd6);
        sample(); chk("fp_ack", {28'h0, unit_ack}, 32'h4);
        chk("fp_head", {29'h0, wb_id}, 32'd0);
        next(); set_u(2, 1'b0, 3'd0); set_u(3, 1'b1, 3'd7); wb_ready = 1'b0;
        sample(); chk("fp_adv", {29'h0, wb_id}, 32'd1);
        chk("fp_still_full", {28'h0, unit_ack}, 32'h0);
        next(); wb_ready = 1'b1;
        sample(); chk("fp_ack3", {28'h0, unit_ack}, 32'h8);
        chk("fp_unit1", {30'h0, wb_unit}, 32'd1);
        next(); set_u(3, 1'b0, 3'd0);
        for (int k = 4; k < 8; k++) begin
            sample();
            chk("drain_id", {29'h0, wb_id}, 32'(k));
            chk("drain_rd", wb_rd, rdv(3'(k)));
            chk("drain_unit", {30'h0, wb_unit}, 32'(k % 4));
            next();
        end
        sample();
        chk("drain_empty", {31'h0, wb_valid}, 32'h0);
        chk("drain_rd0", wb_rd, 32'h0);

        // reset mid-stream, rr_ptr 0
        next(); wb_ready = 1'b0; set_u(0, 1'b1, 3'd1);
        sample(); chk("rs_ack0", {28'h0, unit_ack}, 32'h1);
        next(); set_u(0, 1'b0, 3'd0); set_u(1, 1'b1, 3'd2);
        sample(); chk("rs_ack1", {28'h0, unit_ack}, 32'h2);
        next(); set_u(1, 1'b0, 3'd0); set_u(2, 1'b1, 3'd3);
        sample(); chk("rs_ack2", {28'h0, unit_ack}, 32'h4);
        next(); set_u(2, 1'b0, 3'd0); set_u(0, 1'b1, 3'd0); set_u(3, 1'b1, 3'd3); rst = 1'b1;
        sample(); chk("rs_valid", {31'h0, wb_valid}, 32'h0);
        chk("rs_ack", {28'h0, unit_ack}, 32'h0);
        next(); rst = 1'b0; set_u(1, 1'b1, 3'd1); set_u(2, 1'b1, 3'd2); wb_ready = 1'b1;
        sample(); chk("rs_first", {28'h0, unit_ack}, 32'h1);
        chk("rs_empty", {31'h0, wb_valid}, 32'h0);

        // round robin with all four units held
        for (int k = 1; k <= 4; k++) begin
            next(); sample();
            chk("rr_ack", {28'h0, unit_ack}, 32'(1 << (k % 4)));
            chk("rr_valid", {31'h0, wb_valid}, 32'h1);
            chk("rr_id", {29'h0, wb_id}, 32'((k - 1) % 4));
        end
        next(); unit_done = '0;
        sample(); chk("rr_last", {29'h0, wb_id}, 32'd0);
        chk("rr_noack", {28'h0, unit_ack}, 32'h0);
        next(); sample(); chk("rr_empty", {31'h0, wb_valid}, 32'h0);

        // wrap-around: 10 push/pop pairs
        for (int k = 0; k < 10; k++) begin
            next(); set_u(0, 1'b1, 3'(k % 8));
            sample();
            chk("wr_ack", {28'h0, unit_ack}, 32'h1);
            if (k == 0) chk("wr_valid0", {31'h0, wb_valid}, 32'h0);
            else        chk("wr_id", {29'h0, wb_id}, 32'((k - 1) % 8));
        end
        next(); set_u(0, 1'b0, 3'd0);
        sample(); chk("wr_last", {29'h0, wb_id}, 32'd1);
        chk("wr_noack", {28'h0, unit_ack}, 32'h0);
        next(); sample(); chk("wr_empty", {31'h0, wb_valid}, 32'h0);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end
endmodule

// File: doc/rca_wb_collector.md
# rca_wb_collector

Writeback-side responder for the RCA functional units: the controller end of the unit writeback handshake. It samples `done`/`id`/`rd` from up to `NUM_UNITS` units and returns a one-cycle `ack` to the winning unit under round-robin arbitration. Accepted results go into a small in-order FIFO that drains to the register-file commit port through a valid/ready handshake. It sits between the RCA unit writeback interfaces and the Taiga writeback/commit stage.

## Interface
- `NUM_UNITS`, 4: number of unit writeback ports, 1..8
- `XLEN`, 32: result width
- `ID_WIDTH`, 3: instruction id width
- `DEPTH`, 4: result FIFO entries, power of two ≥ 2
- `clk` in 1: sole clock, rising edge
- `rst` in 1: asynchronous, active-high reset
- `unit_done` in NUM_UNITS: per-unit result-valid (writeback interface `done`)
- `unit_id` in NUM_UNITS×ID_WIDTH: per-unit instruction id
- `unit_rd` in NUM_UNITS×XLEN: per-unit result
- `unit_ack` out NUM_UNITS: per-unit accept pulse, at most one bit high
- `wb_valid` out 1: head FIFO entry valid
- `wb_id` out ID_WIDTH: head entry id
- `wb_rd` out XLEN: head entry result
- `wb_unit` out $clog2(NUM_UNITS) (min 1): index of the unit that produced the head entry
- `wb_ready` in 1: commit stage accepts head entry this cycle

## Operation
- Unit rule: a unit raising `done` holds `done`, `id` and `rd` stable until it samples its `ack` high. It drops `done` the following cycle unless another result is ready.
- `space` = (count < DEPTH) or (wb_valid and wb_ready).
- Grant: the first unit with `done` high, searching from `rr_ptr` upward with wrap. `unit_ack[g]` = `space` and a request exists. `unit_ack` is combinational and forced to 0 while `rst` is high.
- On ack: push {id, rd, g} into the FIFO. `rr_ptr` ← (g+1) mod NUM_UNITS. With no ack, `rr_ptr` holds.
- Pop: when `wb_valid` and `wb_ready`. Push and pop in the same cycle leave count unchanged, and are legal when full.
- FIFO is strictly in acceptance order. Read/write pointers wrap modulo DEPTH. count ranges 0..DEPTH.
- When empty, `wb_valid`=0 and `wb_id`/`wb_rd`/`wb_unit` drive 0.
- Full with no pop: all `unit_ack`=0. Units keep `done` asserted. No result is lost or duplicated.
- `wb_ready` high while `wb_valid` is low has no effect.

## Timing
- Reset values: `unit_ack`=0, `wb_valid`=0, `wb_id`=0, `wb_rd`=0, `wb_unit`=0, count=0, FIFO pointers=0, `rr_ptr`=0.
- Reset asserted mid-operation discards all FIFO contents immediately. Units with `done` high are re-arbitrated after reset.
- Ack latency: `unit_ack` rises in the same cycle as `done` when `space` is true and the unit wins arbitration.
- Result latency without bypass: ack in cycle T gives `wb_valid` with that entry at T+1 at the earliest.
- Throughput: one accept and one commit per cycle, sustained.
- Fairness: a unit with `done` held continuously is acked within NUM_UNITS accepting cycles.
- Combinational paths: `wb_ready` → `unit_ack` (via `space`) and `unit_done` → `unit_ack`. There is no path from `unit_done` to `wb_valid` unless bypass is enabled.

## Configuration
- `RCA_WB_BYPASS_EN` defined:
  - When the FIFO is empty and a unit is granted, the granted result drives `wb_valid`/`wb_id`/`wb_rd`/`wb_unit` in the same cycle.
  - If `wb_ready` is also high, the result commits with zero latency and is not pushed.
  - Otherwise it is pushed as normal and appears again at T+1.
  - In that same-cycle window, `wb_valid` follows `unit_done`. Ack requires `space`, which is true because the FIFO is empty.
- Undefined: no bypass. All results pass through the FIFO with the one-cycle minimum latency above.

## Test plan
- Single result: unit 1 raises done, id=5, rd=0x0000_00FF, `wb_ready`=1. Required: `unit_ack`=4'b0010 in cycle T; `wb_valid` with id=5, rd=0xFF, unit=1 at T+1 (at T with `RCA_WB_BYPASS_EN`).
- Round-robin: units 0..3 hold done continuously with `wb_ready`=1. Required: acks in order 0,1,2,3,0 on consecutive cycles.
- Back-pressure: `wb_ready`=0 with 6 results offered and DEPTH=4. Required: exactly 4 acks, then `unit_ack`=0. On raising `wb_ready`, the entries commit in ack order and the remaining 2 are acked one per cycle.
- Full plus simultaneous pop: FIFO full, `wb_ready`=1, unit 2 done. Required: unit 2 acked the same cycle, count stays 4, head advances.
- Reset mid-stream: 3 entries queued, then assert `rst` for one cycle. Required: `wb_valid`=0 and `unit_ack`=0 during reset, count=0, and the first post-reset grant comes from unit 0 if it requests.
- Wrap-around: 10 push/pop pairs at DEPTH=4 with ids 0..7 repeating. Required: output id sequence equals input order with no gaps or duplicates.
